shift_sched: RTL and testbench

- Scheduler and sequencer for a shared iterative 16-bit shift unit.
- Up to NREQ requesters each present an operand, a shift type and a shift amount. The block grants one requester at a time using round-robin order.
- The granted operation runs as repeated single-bit shifts, one per clock, in an internal working register.
- The block returns the result to the granted requester with a done pulse and ID. It lets several client blocks share one shifter instead of each instantiating a PIPO-style shift register.

---
 rtl/shift_sched.sv | 152 +++++++++++++++
 tb/tb_shift_sched.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// Round-robin scheduler wrapped around one shared iterative shifter.
// Each accepted operation shifts one bit per clock and ends with a one-cycle done pulse.
module shift_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int AMT_W = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ*2-1:0]     req_type,
    input  logic [NREQ*AMT_W-1:0] req_amt,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      result
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    localparam logic [1:0] SH_LRIGHT = 2'd1;
    localparam logic [1:0] SH_ARIGHT = 2'd3;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [1:0]         typ_q, typ_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic               done_q, done_d;
    logic [IDW-1:0]     done_id_q, done_id_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               found;
    logic [IDW-1:0]     pick;
    logic [IDW-1:0]     cand;
    logic [WIDTH-1:0]   sel_data;
    logic [1:0]         sel_type;
    logic [AMT_W-1:0]   sel_amt;

    // Both logical and arithmetic left shifts zero-fill, so only right shifts are distinct.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                   input logic [1:0]       t);
        case (t)
            SH_LRIGHT: shift_one = v >> 1;
            SH_ARIGHT: shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
            default:   shift_one = v << 1;
        endcase
    endfunction

    // Search starts just past the last winner, so a fresh grantee drops to lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(last_q) + off) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign sel_data = req_data[pick*WIDTH +: WIDTH];
    assign sel_type = req_type[pick*2 +: 2];
    assign sel_amt  = req_amt[pick*AMT_W +: AMT_W];

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d   = state_q;
        work_d    = work_q;
        typ_d     = typ_q;
        count_d   = count_q;
        id_d      = id_q;
        last_d    = last_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = NREQ'(1) << pick;
                    work_d  = sel_data;
                    typ_d   = sel_type;
                    count_d = sel_amt;
                    id_d    = pick;
                    last_d  = pick;
                    if (sel_amt == '0) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        done_id_d = pick;
                        result_d  = sel_data;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d  = shift_one(work_q, typ_q);
                count_d = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    result_d  = work_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            work_q    <= '0;
            typ_q     <= '0;
            count_q   <= '0;
            id_q      <= '0;
            last_q    <= IDW'(NREQ - 1);
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            result_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q   <= state_d;
            work_q    <= work_d;
            typ_q     <= typ_d;
            count_q   <= count_d;
            id_q      <= id_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: vector table of single operations plus
// hand-written round-robin, mid-operation reset and operand-capture sequences.
module tb_shift_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int AMT_W = 4;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ*2-1:0]     req_type = '0;
    logic [NREQ*AMT_W-1:0] req_amt = '0;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [1:0]            done_id;
    logic [WIDTH-1:0]      result;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int          k;
        logic [15:0] d;
        logic [1:0]  t;
        logic [3:0]  a;
        logic [15:0] exp;
        bit          scr;
    } vec_t;

    vec_t vecs[10];

    shift_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_type (req_type),
        .req_amt  (req_amt),
        .gnt      (gnt),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_op(input int k, input logic [15:0] d, input logic [1:0] t,
                          input logic [3:0] a);
        req_data[k*WIDTH +: WIDTH] = d;
        req_type[k*2 +: 2]         = t;
        req_amt[k*AMT_W +: AMT_W]  = a;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (busy && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // One operation from a single requester; called at a negedge with the FSM idle
    // or returning to idle on the next edge.
    task automatic run_op(input vec_t v, input string name);
        int          cyc = 0;
        int          g_cyc = -1;
        int          d_cyc = -1;
        int          n_gnt = 0;
        bit          in_op = 1'b0;
        bit          busy_bad = 1'b0;
        logic [3:0]  g_val = '0;
        set_op(v.k, v.d, v.t, v.a);
        req = 4'(1) << v.k;
        while (d_cyc < 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (gnt != '0) begin
                n_gnt++;
                if (g_cyc < 0) begin
                    g_cyc = cyc;
                    g_val = gnt;
                    in_op = 1'b1;
                end
                req = '0;
                if (v.scr) set_op(v.k, ~v.d, 2'd3, 4'd15);
            end
            if (in_op && !busy) busy_bad = 1'b1;
            if (done) begin
                d_cyc = cyc;
                check({name, "_done_id"}, 32'(done_id), 32'(v.k));
                check({name, "_result"}, 32'(result), 32'(v.exp));
            end
        end
        check({name, "_done_seen"}, 32'(d_cyc >= 0), 32'd1);
        check({name, "_gnt"}, 32'(g_val), 32'(4'(1) << v.k));
        check({name, "_gnt_count"}, 32'(n_gnt), 32'd1);
        check({name, "_latency"}, 32'(d_cyc - g_cyc), 32'(v.a));
        check({name, "_busy"}, 32'(busy_bad), 32'd0);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done), 32'd0);
        check({name, "_result_hold"}, 32'(result), 32'(v.exp));
    endtask

    initial begin
        int          order[6];
        int          gcyc[6];
        int          exp_order[6] = '{0, 1, 2, 3, 0, 1};
        int          rr_amt[4] = '{1, 2, 0, 3};
        int          n;
        int          cyc;
        int          idx;
        bit          saw_done;
        logic [3:0]  raise_mask;

        vecs[0] = '{0, 16'h00F0, 2'd0, 4'd4,  16'h0F00, 1'b0};
        vecs[1] = '{2, 16'h8001, 2'd3, 4'd4,  16'hF800, 1'b0};
        vecs[2] = '{2, 16'h8001, 2'd1, 4'd4,  16'h0800, 1'b0};
        vecs[3] = '{1, 16'h8000, 2'd1, 4'd15, 16'h0001, 1'b0};
        vecs[4] = '{0, 16'h1234, 2'd0, 4'd0,  16'h1234, 1'b0};
        vecs[5] = '{3, 16'h0001, 2'd2, 4'd15, 16'h8000, 1'b0};
        vecs[6] = '{3, 16'h4000, 2'd3, 4'd3,  16'h0800, 1'b0};
        vecs[7] = '{1, 16'hFFFF, 2'd0, 4'd1,  16'hFFFE, 1'b0};
        vecs[8] = '{1, 16'hC000, 2'd2, 4'd2,  16'h0000, 1'b0};
        vecs[9] = '{1, 16'h0003, 2'd0, 4'd5,  16'h0060, 1'b1};

        #3 reset = 1'b0;
        #9;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        // Round robin: all four request, each drops on grant and re-raises a cycle later.
        apply_reset();
        for (int k = 0; k < 4; k++) set_op(k, 16'(k + 1), 2'd0, 4'(rr_amt[k]));
        req = 4'b1111;
        n = 0;
        cyc = 0;
        raise_mask = '0;
        while (n < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            req = req | raise_mask;
            raise_mask = '0;
            if (gnt != '0) begin
                check($sformatf("rr_onehot%0d", n), 32'($countones(gnt)), 32'd1);
                idx = -1;
                for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
                order[n] = idx;
                gcyc[n]  = cyc;
                n++;
                req = req & ~gnt;
                raise_mask = gnt;
            end
        end
        req = '0;
        check("rr_grants", 32'(n), 32'd6);
        for (int i = 0; i < n; i++)
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        for (int i = 0; i + 1 < n; i++)
            check($sformatf("rr_gap%0d", i), 32'(gcyc[i+1] - gcyc[i]),
                  32'(rr_amt[exp_order[i]] + 2));
        wait_idle("rr");

        // Reset in the third SHIFT cycle of a long operation from requester 3.
        @(negedge clk);
        set_op(3, 16'h0001, 2'd0, 4'd10);
        req = 4'b1000;
        cyc = 0;
        while (gnt == '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_gnt", 32'(gnt), 32'b1000);
        req = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_gnt0", 32'(gnt), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_done_id", 32'(done_id), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        set_op(0, 16'h0010, 2'd1, 4'd1);
        set_op(3, 16'h0001, 2'd0, 4'd10);
        req = 4'b1001;
        reset = 1'b1;
        cyc = 0;
        while (gnt == '0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", 32'(saw_done), 32'd0);
        check("post_rst_gnt", 32'(gnt), 32'b0001);
        req = '0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_result", 32'(result), 32'h0008);
        check("post_rst_done_id", 32'(done_id), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
